// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held until the requester drops start_i.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom.
  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r <= signed_div_i & opdata1_i[WIDTH-1];
              dvd   <= op1_mag;
              dsr   <= op2_mag;
              rem   <= '0;
              cnt   <= '0;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt == CW'(WIDTH)) begin
            state    <= END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end else begin
            rem <= diff[WIDTH] ? shifted : diff;
            dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + CW'(1);
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule
